// File: rtl/pwm_cfg_sequencer.sv
// AXI4-Lite master that writes a latched register image into the PWM slave, then reads
// every register back and compares it, reporting pass/fail with the failing index.
module pwm_cfg_sequencer #(
  parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned                   C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0,
  parameter int unsigned                   NUM_REGS           = 4,
  parameter int unsigned                   TIMEOUT_CYCLES     = 256
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  input  logic                                   start,
  input  logic [C_M_AXI_DATA_WIDTH*NUM_REGS-1:0] cfg_data,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   error,
  output logic [1:0]                             err_code,
  output logic [3:0]                             err_idx,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]          m_axi_awaddr,
  output logic [2:0]                             m_axi_awprot,
  output logic                                   m_axi_awvalid,
  input  logic                                   m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]          m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]        m_axi_wstrb,
  output logic                                   m_axi_wvalid,
  input  logic                                   m_axi_wready,
  input  logic [1:0]                             m_axi_bresp,
  input  logic                                   m_axi_bvalid,
  output logic                                   m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]          m_axi_araddr,
  output logic [2:0]                             m_axi_arprot,
  output logic                                   m_axi_arvalid,
  input  logic                                   m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]          m_axi_rdata,
  input  logic [1:0]                             m_axi_rresp,
  input  logic                                   m_axi_rvalid,
  output logic                                   m_axi_rready
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ErrNone = 2'd0;
  localparam logic [1:0] ErrBresp = 2'd1;
  localparam logic [1:0] ErrRead = 2'd2;
  localparam logic [1:0] ErrTimeout = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWresp,
    StRd,
    StRdata,
    StDone
  } state_e;

  state_e                                      state_q, state_d;
  logic [3:0]                                  idx_q, idx_d;
  logic [NUM_REGS-1:0][C_M_AXI_DATA_WIDTH-1:0] cfg_q;
  logic                                        cfg_load;
  logic                                        aw_done_q, aw_done_d;
  logic                                        w_done_q, w_done_d;
  logic [TmoW-1:0]                             tmo_q, tmo_d;
  logic                                        error_q, error_d;
  logic [1:0]                                  err_code_q, err_code_d;
  logic [3:0]                                  err_idx_q, err_idx_d;

  logic [C_M_AXI_DATA_WIDTH-1:0]               reg_val;
  logic [C_M_AXI_ADDR_WIDTH-1:0]               reg_addr;
  logic                                        last_idx;
  logic                                        tmo_expired;
  logic                                        aw_ok;
  logic                                        w_ok;

  always_comb begin
    reg_val = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (idx_q == 4'(k)) reg_val = cfg_q[k];
    end
  end

  assign reg_addr    = C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx_q, 2'b00});
  assign last_idx    = (idx_q == 4'(NUM_REGS - 1));
  assign tmo_expired = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
  assign aw_ok       = aw_done_q | m_axi_awready;
  assign w_ok        = w_done_q | m_axi_wready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cfg_load   = 1'b0;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    tmo_d      = tmo_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    err_idx_d  = err_idx_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cfg_load   = 1'b1;
          idx_d      = '0;
          error_d    = 1'b0;
          err_code_d = ErrNone;
          err_idx_d  = '0;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          tmo_d      = '0;
          state_d    = StWr;
        end
      end

      // AW and W complete independently; each valid drops once its own ready is seen.
      StWr: begin
        aw_done_d = aw_ok;
        w_done_d  = w_ok;
        if (aw_ok && w_ok) begin
          tmo_d   = '0;
          state_d = StWresp;
        end else if (tmo_expired) begin
          error_d    = 1'b1;
          err_code_d = ErrTimeout;
          err_idx_d  = idx_q;
          state_d    = StDone;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      StWresp: begin
        if (m_axi_bvalid) begin
          tmo_d = '0;
          if (m_axi_bresp != 2'b00) begin
            error_d    = 1'b1;
            err_code_d = ErrBresp;
            err_idx_d  = idx_q;
            state_d    = StDone;
          end else if (last_idx) begin
            idx_d   = '0;
            state_d = StRd;
          end else begin
            idx_d     = idx_q + 4'd1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = StWr;
          end
        end else if (tmo_expired) begin
          error_d    = 1'b1;
          err_code_d = ErrTimeout;
          err_idx_d  = idx_q;
          state_d    = StDone;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      StRd: begin
        if (m_axi_arready) begin
          tmo_d   = '0;
          state_d = StRdata;
        end else if (tmo_expired) begin
          error_d    = 1'b1;
          err_code_d = ErrTimeout;
          err_idx_d  = idx_q;
          state_d    = StDone;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      StRdata: begin
        if (m_axi_rvalid) begin
          tmo_d = '0;
          if ((m_axi_rresp != 2'b00) || (m_axi_rdata != reg_val)) begin
            error_d    = 1'b1;
            err_code_d = ErrRead;
            err_idx_d  = idx_q;
            state_d    = StDone;
          end else if (last_idx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = StRd;
          end
        end else if (tmo_expired) begin
          error_d    = 1'b1;
          err_code_d = ErrTimeout;
          err_idx_d  = idx_q;
          state_d    = StDone;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cfg_q      <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      tmo_q      <= '0;
      error_q    <= 1'b0;
      err_code_q <= ErrNone;
      err_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      tmo_q      <= tmo_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      err_idx_q  <= err_idx_d;
      if (cfg_load) cfg_q <= cfg_data;
    end
  end

  // All outputs decode from registered state only, so reset clears them without delay.
  assign busy     = state_q inside {StWr, StWresp, StRd, StRdata};
  assign done     = (state_q == StDone);
  assign error    = error_q;
  assign err_code = err_code_q;
  assign err_idx  = err_idx_q;

  assign m_axi_awvalid = (state_q == StWr) && !aw_done_q;
  assign m_axi_wvalid  = (state_q == StWr) && !w_done_q;
  assign m_axi_awaddr  = (state_q == StWr) ? reg_addr : '0;
  assign m_axi_wdata   = (state_q == StWr) ? reg_val : '0;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wstrb   = '1;
  assign m_axi_bready  = (state_q == StWresp);

  assign m_axi_arvalid = (state_q == StRd);
  assign m_axi_araddr  = (state_q == StRd) ? reg_addr : '0;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_rready  = (state_q == StRdata);

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Directed bench for pwm_cfg_sequencer with a configurable AXI4-Lite slave model
// (awready delay, bresp error, readback corruption, arready stall).
module tb_pwm_cfg_sequencer;

  logic         ACLK;
  logic         ARESETN;
  logic         start;
  logic [127:0] cfg_data;
  logic         busy, done, error;
  logic [1:0]   err_code;
  logic [3:0]   err_idx;
  logic [31:0]  awaddr, araddr, wdata, rdata;
  logic [2:0]   awprot, arprot;
  logic [3:0]   wstrb;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [1:0]   bresp, rresp;

  pwm_cfg_sequencer #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .start        (start),
    .cfg_data     (cfg_data),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_code     (err_code),
    .err_idx      (err_idx),
    .m_axi_awaddr (awaddr),
    .m_axi_awprot (awprot),
    .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata  (wdata),
    .m_axi_wstrb  (wstrb),
    .m_axi_wvalid (wvalid),
    .m_axi_wready (wready),
    .m_axi_bresp  (bresp),
    .m_axi_bvalid (bvalid),
    .m_axi_bready (bready),
    .m_axi_araddr (araddr),
    .m_axi_arprot (arprot),
    .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rdata  (rdata),
    .m_axi_rresp  (rresp),
    .m_axi_rvalid (rvalid),
    .m_axi_rready (rready)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_chk = 0;
  int n_fail = 0;

  // Slave knobs
  int aw_delay = 0;
  int bresp_err_idx = -1;
  int corrupt_idx = -1;
  bit ar_never = 1'b0;

  // Monitor counters (written only by the monitor)
  int          n_aw = 0, n_w = 0, n_ar = 0, done_cnt = 0;
  int          aw_hi = 0, w_hi = 0, ar_hi = 0, aw_unstable = 0;
  logic [31:0] aw_log [64];
  logic [31:0] w_log [64];

  // Sequence results (written only by run_seq)
  int   seq_lat;
  bit   seq_got;
  logic seq_busy1, seq_err1, seq_busy_done, seq_done_after, seq_err_after;

  // Slave model: handshakes sampled on negedge, responses driven #1 after posedge.
  initial begin
    logic [31:0] mem [16];
    logic [31:0] pend_addr, pend_data, ar_lat;
    bit s_aw, s_w, s_b, s_ar, s_r, got_aw, got_w;
    int aw_cnt;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0;
    got_aw = 0; got_w = 0; aw_cnt = 0;
    pend_addr = 0; pend_data = 0; ar_lat = 0;
    forever begin
      @(negedge ACLK);
      s_aw = awvalid && awready;
      s_w  = wvalid && wready;
      s_b  = bvalid && bready;
      s_ar = arvalid && arready;
      s_r  = rvalid && rready;
      if (s_aw) pend_addr = awaddr;
      if (s_w) pend_data = wdata;
      if (s_ar) ar_lat = araddr;
      if (awvalid && !awready) aw_cnt++;
      @(posedge ACLK);
      #1;
      if (!ARESETN) begin
        got_aw = 0; got_w = 0; aw_cnt = 0;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      end else begin
        if (s_aw) begin got_aw = 1; aw_cnt = 0; end
        if (s_w) got_w = 1;
        if (s_b) bvalid = 0;
        if (s_r) rvalid = 0;
        if (got_aw && got_w) begin
          mem[pend_addr[5:2]] = pend_data;
          bresp  = (int'(pend_addr[5:2]) == bresp_err_idx) ? 2'b10 : 2'b00;
          bvalid = 1;
          got_aw = 0; got_w = 0;
        end
        if (s_ar) begin
          rdata  = mem[ar_lat[5:2]] + ((int'(ar_lat[5:2]) == corrupt_idx) ? 32'd1 : 32'd0);
          rresp  = 2'b00;
          rvalid = 1;
        end
        awready = awvalid && (aw_cnt >= aw_delay);
        wready  = wvalid;
        arready = arvalid && !ar_never;
      end
    end
  end

  // Monitor
  initial begin
    bit          aw_pend;
    logic [31:0] aw_prev;
    aw_pend = 0; aw_prev = 0;
    forever begin
      @(negedge ACLK);
      if (awvalid && awready) begin
        if (n_aw < 64) aw_log[n_aw] = awaddr;
        n_aw++;
      end
      if (wvalid && wready) begin
        if (n_w < 64) w_log[n_w] = wdata;
        n_w++;
      end
      if (arvalid && arready) n_ar++;
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      if (arvalid) ar_hi++;
      if (done) done_cnt++;
      if (awvalid && aw_pend && awaddr != aw_prev) aw_unstable++;
      aw_pend = awvalid && !awready;
      aw_prev = awaddr;
    end
  end

  task automatic run_seq(input logic [127:0] cfg, input int poke);
    @(posedge ACLK);
    #1;
    cfg_data = cfg;
    start    = 1'b1;
    seq_lat  = 0;
    seq_got  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge ACLK);
      #1;
      start = 1'b0;
      seq_lat++;
      if (seq_lat == 1) begin
        seq_busy1 = busy;
        seq_err1  = error;
      end
      if (poke != 0 && seq_lat == poke) begin
        start    = 1'b1;
        cfg_data = ~cfg;
      end
      if (done) begin
        seq_got = 1'b1;
        break;
      end
    end
    seq_lat++;  // count the start cycle itself
    seq_busy_done = busy;
    @(posedge ACLK);
    #1;
    start          = 1'b0;
    seq_done_after = done;
    seq_err_after  = error;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0; start = 1'b0; cfg_data = '0;
    repeat (3) @(posedge ACLK);
    #1;
    n_chk++;
    if ({awvalid, wvalid, bready, arvalid, rready, busy, done, error, err_code, err_idx} !== 13'd0)
      begin n_fail++; $display("FAIL reset_outputs: got %b want 0", {awvalid, wvalid, bready,
        arvalid, rready, busy, done, error, err_code, err_idx}); end
    n_chk++;
    if ({awprot, arprot, wstrb} !== 10'b000_000_1111)
      begin n_fail++; $display("FAIL reset_ties: got %b want 0000001111", {awprot, arprot, wstrb}); end
    ARESETN = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    n_chk++;
    if ({awvalid, arvalid, busy, done} !== 4'd0)
      begin n_fail++; $display("FAIL idle_after_reset: got %b want 0000", {awvalid, arvalid, busy, done}); end
  endtask

  task automatic test_zero_wait();
    int b_aw = n_aw, b_w = n_w, b_ar = n_ar;
    run_seq({32'd4, 32'd3, 32'd2, 32'd1}, 0);
    n_chk++; if (!seq_got) begin n_fail++; $display("FAIL t1_done: got none want pulse"); end
    n_chk++; if (seq_lat != 18) begin n_fail++; $display("FAIL t1_latency: got %0d want 18", seq_lat); end
    n_chk++; if (seq_busy1 !== 1'b1) begin n_fail++; $display("FAIL t1_busy: got %b want 1", seq_busy1); end
    n_chk++; if (seq_busy_done !== 1'b0) begin n_fail++; $display("FAIL t1_busy_at_done: got %b want 0", seq_busy_done); end
    n_chk++; if (seq_done_after !== 1'b0) begin n_fail++; $display("FAIL t1_done_width: got %b want 0", seq_done_after); end
    n_chk++; if ({error, err_code} !== 3'd0) begin n_fail++; $display("FAIL t1_error: got %b want 000", {error, err_code}); end
    n_chk++; if (n_aw - b_aw != 4) begin n_fail++; $display("FAIL t1_nwrites: got %0d want 4", n_aw - b_aw); end
    n_chk++; if (n_ar - b_ar != 4) begin n_fail++; $display("FAIL t1_nreads: got %0d want 4", n_ar - b_ar); end
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (aw_log[b_aw + k] !== 32'(4 * k) || w_log[b_w + k] !== 32'(k + 1)) begin
        n_fail++;
        $display("FAIL t1_write%0d: got addr %0h data %0h want addr %0h data %0h", k,
                 aw_log[b_aw + k], w_log[b_w + k], 4 * k, k + 1);
      end
    end
  endtask

  task automatic test_aw_delay();
    int b_awhi = aw_hi, b_whi = w_hi, b_unst = aw_unstable, b_w = n_w, b_done = done_cnt;
    logic [127:0] cfg = {32'hCAFE_0004, 32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001};
    aw_delay = 3;
    run_seq(cfg, 3);  // also pulses start and changes cfg_data mid-sequence
    aw_delay = 0;
    repeat (3) @(posedge ACLK);
    #1;
    n_chk++; if (!seq_got || error !== 1'b0) begin n_fail++; $display("FAIL t2_pass: got done=%b error=%b want 1 0", seq_got, error); end
    n_chk++; if (aw_hi - b_awhi != 16) begin n_fail++; $display("FAIL t2_awvalid_cycles: got %0d want 16", aw_hi - b_awhi); end
    n_chk++; if (w_hi - b_whi != 4) begin n_fail++; $display("FAIL t2_wvalid_cycles: got %0d want 4", w_hi - b_whi); end
    n_chk++; if (aw_unstable != b_unst) begin n_fail++; $display("FAIL t2_awaddr_stable: got %0d changes want 0", aw_unstable - b_unst); end
    n_chk++; if (w_log[b_w + 3] !== 32'hCAFE_0004) begin n_fail++; $display("FAIL t2_latched_cfg: got %0h want cafe0004", w_log[b_w + 3]); end
    n_chk++; if (done_cnt - b_done != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL t2_start_ignored: got dones=%0d busy=%b want 1 0", done_cnt - b_done, busy); end
  endtask

  task automatic test_bresp_err();
    int b_aw = n_aw, b_ar = n_ar;
    bresp_err_idx = 2;
    run_seq({32'd40, 32'd30, 32'd20, 32'd10}, 0);
    bresp_err_idx = -1;
    n_chk++; if (!seq_got) begin n_fail++; $display("FAIL t3_done: got none want pulse"); end
    n_chk++; if ({seq_err_after, err_code, err_idx} !== {1'b1, 2'd1, 4'd2}) begin n_fail++; $display("FAIL t3_err: got %b/%0d/%0d want 1/1/2", seq_err_after, err_code, err_idx); end
    n_chk++; if (n_ar - b_ar != 0 || n_aw - b_aw != 3) begin n_fail++; $display("FAIL t3_traffic: got reads=%0d writes=%0d want 0 3", n_ar - b_ar, n_aw - b_aw); end
  endtask

  task automatic test_read_mismatch();
    int b_ar = n_ar;
    corrupt_idx = 3;
    run_seq({32'd4, 32'd3, 32'd2, 32'd1}, 0);
    corrupt_idx = -1;
    n_chk++; if (seq_err1 !== 1'b0) begin n_fail++; $display("FAIL t4_error_cleared: got %b want 0", seq_err1); end
    n_chk++; if ({error, err_code, err_idx} !== {1'b1, 2'd2, 4'd3}) begin n_fail++; $display("FAIL t4_err: got %b/%0d/%0d want 1/2/3", error, err_code, err_idx); end
    n_chk++; if (n_ar - b_ar != 4) begin n_fail++; $display("FAIL t4_nreads: got %0d want 4", n_ar - b_ar); end
  endtask

  task automatic test_ar_timeout();
    int b_arhi = ar_hi, b_ar = n_ar;
    ar_never = 1'b1;
    run_seq({32'd4, 32'd3, 32'd2, 32'd1}, 0);
    n_chk++; if (!seq_got) begin n_fail++; $display("FAIL t5_done: got none want pulse"); end
    n_chk++; if (ar_hi - b_arhi != 16) begin n_fail++; $display("FAIL t5_arvalid_cycles: got %0d want 16", ar_hi - b_arhi); end
    n_chk++; if ({error, err_code, err_idx} !== {1'b1, 2'd3, 4'd0}) begin n_fail++; $display("FAIL t5_err: got %b/%0d/%0d want 1/3/0", error, err_code, err_idx); end
    n_chk++; if (arvalid !== 1'b0 || n_ar != b_ar) begin n_fail++; $display("FAIL t5_ar_dropped: got arvalid=%b hs=%0d want 0 0", arvalid, n_ar - b_ar); end
    ar_never = 1'b0;
  endtask

  task automatic test_reset_mid();
    int  b_done, b_aw;
    bit  hit = 0;
    @(posedge ACLK);
    #1;
    cfg_data = {32'd8, 32'd7, 32'd6, 32'd5};
    start    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge ACLK);
      #1;
      start = 1'b0;
      if (bready) begin hit = 1; break; end
    end
    n_chk++; if (!hit) begin n_fail++; $display("FAIL t6_reach_wresp: got no bready want bready"); end
    b_done  = done_cnt;
    ARESETN = 1'b0;
    #1;
    n_chk++;
    if ({awvalid, wvalid, bready, arvalid, rready, busy, done, error, err_code, err_idx} !== 13'd0)
      begin n_fail++; $display("FAIL t6_reset_outputs: got %b want 0", {awvalid, wvalid, bready,
        arvalid, rready, busy, done, error, err_code, err_idx}); end
    repeat (3) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    n_chk++; if (done_cnt != b_done) begin n_fail++; $display("FAIL t6_no_done: got %0d dones want 0", done_cnt - b_done); end
    b_aw = n_aw;
    run_seq({32'd4, 32'd3, 32'd2, 32'd1}, 0);
    n_chk++; if (!seq_got || seq_lat != 18) begin n_fail++; $display("FAIL t6_clean_seq: got done=%b lat=%0d want 1 18", seq_got, seq_lat); end
    n_chk++; if (error !== 1'b0 || n_aw - b_aw != 4) begin n_fail++; $display("FAIL t6_clean_result: got error=%b writes=%0d want 0 4", error, n_aw - b_aw); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_aw_delay();
    test_bresp_err();
    test_read_mismatch();
    test_ar_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
